serial_frame_rx: RTL and testbench

// - Receiver end of the team's one-wire serial frame link: recovers frames driven by the serial

---
 rtl/serial_frame_pkg.sv | 20 ++
 rtl/serial_bit_timer.sv | 30 +++
 rtl/serial_frame_rx.sv | 173 +++++++++++++++++
 tb/tb_serial_frame_rx.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_pkg.sv
// rtl/serial_frame_pkg.sv - shared types, constants and helpers for the serial frame receiver
package serial_frame_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam int SYNC_STAGES = 2;
  localparam int MAX_DATA_W  = 9;

  // Even parity of a word zero-extended to the widest supported frame
  function automatic logic even_parity(input logic [MAX_DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// rtl/serial_bit_timer.sv - per-bit cycle counter with half-bit and full-bit ticks
module serial_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic half_tick,
  output logic full_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] r_count;

  // Count 0..CLKS_PER_BIT-1, wrapping at the end of a bit or on restart
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (restart || full_tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign half_tick = (r_count == CW'(CLKS_PER_BIT/2 - 1));
  assign full_tick = (r_count == CW'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - one-wire serial frame receiver with valid/ready byte output
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8,
  parameter int PARITY_EN    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_line,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun,
  input  logic              err_clr
);

  logic [SYNC_STAGES-1:0] r_sync;
  rx_state_e              r_state;
  rx_state_e              w_state_next;
  logic [3:0]             r_bit_idx;
  logic [DATA_W-1:0]      r_data;
  logic [DATA_W-1:0]      r_out_data;
  logic                   r_out_valid;
  logic                   r_frame_err;
  logic                   r_parity_err;
  logic                   r_overrun;
  logic                   r_armed;
  logic                   w_rx_s;
  logic                   w_half_tick;
  logic                   w_full_tick;
  logic                   w_has_parity;
  logic                   w_perr;
  logic                   w_stop_sample;
  logic                   w_good;
  logic                   w_ferr_evt;
  logic                   w_perr_evt;
  logic                   w_ovr_evt;

  // Two-flop synchroniser for the asynchronous pad; idles high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rx_line};
    end
  end

  assign w_rx_s = r_sync[SYNC_STAGES-1];

  serial_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (w_state_next != r_state),
    .half_tick(w_half_tick),
    .full_tick(w_full_tick)
  );

  generate
    if (PARITY_EN != 0) begin : g_parity
      logic r_perr;
      // Latch the parity verdict at the parity-bit sample for use at the stop sample
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_perr <= 1'b0;
        end else if (r_state == PARITY && w_full_tick) begin
          r_perr <= even_parity(MAX_DATA_W'(r_data)) ^ w_rx_s;
        end
      end
      assign w_perr       = r_perr;
      assign w_has_parity = 1'b1;
    end else begin : g_no_parity
      assign w_perr       = 1'b0;
      assign w_has_parity = 1'b0;
    end
  endgenerate

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state decode
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (r_armed && !w_rx_s) w_state_next = START;
      START:   if (w_half_tick) w_state_next = w_rx_s ? IDLE : DATA;
      DATA:    if (w_full_tick && r_bit_idx == 4'(DATA_W - 1))
                 w_state_next = w_has_parity ? PARITY : STOP;
      PARITY:  if (w_full_tick) w_state_next = STOP;
      STOP:    if (w_full_tick) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Shift data bits in LSB first at each mid-bit sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data    <= '0;
      r_bit_idx <= '0;
    end else if (r_state == START) begin
      r_bit_idx <= '0;
    end else if (r_state == DATA && w_full_tick) begin
      r_data    <= {w_rx_s, r_data[DATA_W-1:1]};
      r_bit_idx <= r_bit_idx + 1'b1;
    end
  end

  assign w_stop_sample = (r_state == STOP) && w_full_tick;
  assign w_ferr_evt    = w_stop_sample && !w_rx_s;
  assign w_perr_evt    = w_stop_sample && w_rx_s && w_perr;
  assign w_good        = w_stop_sample && w_rx_s && !w_perr;
  assign w_ovr_evt     = w_good && r_out_valid && !out_ready;

  // Output holding register with valid/ready handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_good && (!r_out_valid || out_ready)) begin
      r_out_data  <= r_data;
      r_out_valid <= 1'b1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Sticky error flags; a new error in the clear cycle still sets the flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (err_clr) begin
        r_frame_err  <= 1'b0;
        r_parity_err <= 1'b0;
        r_overrun    <= 1'b0;
      end
      if (w_ferr_evt) r_frame_err  <= 1'b1;
      if (w_perr_evt) r_parity_err <= 1'b1;
      if (w_ovr_evt)  r_overrun    <= 1'b1;
    end
  end

  // After a bad stop bit, ignore a held-low line until it returns high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed <= 1'b1;
    end else if (w_ferr_evt) begin
      r_armed <= 1'b0;
    end else if (w_rx_s) begin
      r_armed <= 1'b1;
    end
  end

  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb/tb_serial_frame_rx.sv - self-checking bench for serial_frame_rx
module tb_serial_frame_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_line = 1'b1;
  logic       out_ready = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] got_q[$];
  int         valid_cycles = 0;

  serial_frame_rx #(
    .CLKS_PER_BIT(CPB),
    .DATA_W      (8),
    .PARITY_EN   (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_line   (rx_line),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  // Record every accepted word and count cycles with valid high
  always @(posedge clk) begin
    if (rst_n) begin
      if (out_valid) valid_cycles++;
      if (out_valid && out_ready) got_q.push_back(out_data);
    end
  end

  task automatic drive_bit(input logic b);
    rx_line = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(s);
  endtask

  task automatic idle_bits(input int n);
    rx_line = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic clear_flags();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic expect_one(input string name, input logic [7:0] exp);
    n_tests++;
    if (got_q.size() != 1 || got_q[0] !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d words first=%h, required 1 word %h",
               name, got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'h00, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({out_data, out_valid, frame_err, parity_err, overrun} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%h v=%b fe=%b pe=%b ov=%b, required all 0",
               out_data, out_valid, frame_err, parity_err, overrun);
    end
    rst_n = 1'b1;
    idle_bits(1);
  endtask

  task automatic test_good_frame();
    out_ready = 1'b1;
    got_q.delete();
    valid_cycles = 0;
    send_frame(8'hA5, 1'b0, 1'b1);
    idle_bits(2);
    expect_one("good_a5", 8'hA5);
    n_tests++;
    if (valid_cycles != 1) begin
      n_fail++;
      $display("FAIL good_valid_cycles: got %0d, required 1", valid_cycles);
    end
    n_tests++;
    if ({frame_err, parity_err, overrun} !== 3'b000) begin
      n_fail++;
      $display("FAIL good_flags: got %b, required 000", {frame_err, parity_err, overrun});
    end
  endtask

  task automatic test_glitch();
    got_q.delete();
    rx_line = 1'b0;
    repeat (6) @(negedge clk);
    idle_bits(3);
    n_tests++;
    if (got_q.size() != 0 || {frame_err, parity_err, overrun} !== 3'b000) begin
      n_fail++;
      $display("FAIL glitch: got %0d words flags=%b, required 0 words flags 000",
               got_q.size(), {frame_err, parity_err, overrun});
    end
    send_frame(8'h5A, 1'b0, 1'b1);
    idle_bits(2);
    expect_one("after_glitch_5a", 8'h5A);
  endtask

  task automatic test_parity_err();
    got_q.delete();
    send_frame(8'h3C, 1'b1, 1'b1);
    idle_bits(2);
    n_tests++;
    if (parity_err !== 1'b1 || frame_err !== 1'b0 || got_q.size() != 0) begin
      n_fail++;
      $display("FAIL parity_err_set: got pe=%b fe=%b words=%0d, required pe=1 fe=0 words=0",
               parity_err, frame_err, got_q.size());
    end
    clear_flags();
    n_tests++;
    if (parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_err_clear: got %b, required 0", parity_err);
    end
  endtask

  task automatic test_frame_err_break();
    got_q.delete();
    send_frame(8'h55, 1'b0, 1'b0);
    n_tests++;
    if (frame_err !== 1'b1 || got_q.size() != 0) begin
      n_fail++;
      $display("FAIL frame_err_set: got fe=%b words=%0d, required fe=1 words=0",
               frame_err, got_q.size());
    end
    rx_line = 1'b0;
    repeat (40 * CPB) @(negedge clk);
    idle_bits(2);
    n_tests++;
    if (got_q.size() != 0 || parity_err !== 1'b0 || frame_err !== 1'b1) begin
      n_fail++;
      $display("FAIL break_no_frame: got words=%0d pe=%b fe=%b, required 0 0 1",
               got_q.size(), parity_err, frame_err);
    end
    clear_flags();
    send_frame(8'h81, 1'b0, 1'b1);
    idle_bits(2);
    expect_one("rearm_81", 8'h81);
  endtask

  task automatic test_overrun();
    got_q.delete();
    out_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1);
    idle_bits(1);
    send_frame(8'h22, 1'b0, 1'b1);
    idle_bits(2);
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 8'h11 || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_hold: got v=%b data=%h ov=%b, required v=1 data=11 ov=1",
               out_valid, out_data, overrun);
    end
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    expect_one("overrun_accept_11", 8'h11);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_valid_drop: got %b, required 0", out_valid);
    end
    clear_flags();
  endtask

  task automatic test_reset_midframe();
    got_q.delete();
    out_ready = 1'b1;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    rx_line = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({out_data, out_valid, frame_err, parity_err, overrun} !== 12'h000) begin
      n_fail++;
      $display("FAIL midframe_reset_outputs: got data=%h v=%b fe=%b pe=%b ov=%b, required all 0",
               out_data, out_valid, frame_err, parity_err, overrun);
    end
    rst_n = 1'b1;
    idle_bits(8);
    n_tests++;
    if (got_q.size() != 0) begin
      n_fail++;
      $display("FAIL midframe_partial: got %0d words, required 0", got_q.size());
    end
    send_frame(8'h0F, 1'b0, 1'b1);
    idle_bits(2);
    expect_one("after_reset_0f", 8'h0F);
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic       exp_fe;
    logic       exp_pe;
    logic [7:0] d;
    logic       bad_par;
    logic       bad_stop;
    got_q.delete();
    out_ready = 1'b1;
    exp_fe = 1'b0;
    exp_pe = 1'b0;
    for (int f = 0; f < 24; f++) begin
      d        = 8'($urandom);
      bad_par  = ($urandom_range(0, 3) == 0);
      bad_stop = ($urandom_range(0, 4) == 0);
      send_frame(d, (^d) ^ bad_par, !bad_stop);
      idle_bits(1 + $urandom_range(0, 2));
      if (bad_stop) exp_fe = 1'b1;
      else if (bad_par) exp_pe = 1'b1;
      else exp_q.push_back(d);
    end
    n_tests++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL random_count: got %0d words, required %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_tests++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL random_word[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    n_tests++;
    if ({frame_err, parity_err, overrun} !== {exp_fe, exp_pe, 1'b0}) begin
      n_fail++;
      $display("FAIL random_flags: got %b, required %b",
               {frame_err, parity_err, overrun}, {exp_fe, exp_pe, 1'b0});
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_glitch();
    test_parity_err();
    test_frame_err_break();
    test_overrun();
    test_reset_midframe();
    clear_flags();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
